// File: rtl/bridge_1xn_pkg.sv
// Shared constants for the 1-to-N data-side bridge: datapath width, miss data, default windows.
// No logic.
// No flow control.
package bridge_1xn_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] MISS_DATA_DEF = 32'hDEAD_BEEF;

    // Data SRAM is the catch-all window; confreg claims 0xBFAF_xxxx.
    localparam logic [XLEN-1:0] DSRAM_BASE = 32'h0000_0000;
    localparam logic [XLEN-1:0] DSRAM_MASK = 32'h0000_0000;
    localparam logic [XLEN-1:0] CONF_BASE  = 32'hBFAF_0000;
    localparam logic [XLEN-1:0] CONF_MASK  = 32'hFFFF_0000;

endpackage

// File: rtl/bridge_1xn_if.sv
// CPU data port plus fanned-out slave ports of the bridge.
// Latency is defined by the bridge: requests 0 cycles, read data 1 cycle.
// No backpressure: the port has no stall signal.
interface bridge_1xn_if
    import bridge_1xn_pkg::*;
#(
    parameter int N_SLV = 2
) ();

    logic                             cpu_data_en;
    logic [3:0]                       cpu_data_wen;
    logic [XLEN-1:0]                  cpu_data_addr;
    logic [XLEN-1:0]                  cpu_data_wdata;
    logic [XLEN-1:0]                  cpu_data_rdata;

    logic [N_SLV-1:0]                 slv_en;
    logic [N_SLV-1:0][3:0]            slv_wen;
    logic [N_SLV-1:0][XLEN-1:0]       slv_addr;
    logic [N_SLV-1:0][XLEN-1:0]       slv_wdata;
    logic [N_SLV-1:0][XLEN-1:0]       slv_rdata;

    // Environment side: CPU requests and slave read data.
    modport master (
        output cpu_data_en, cpu_data_wen, cpu_data_addr, cpu_data_wdata,
        input  cpu_data_rdata,
        input  slv_en, slv_wen, slv_addr, slv_wdata,
        output slv_rdata
    );

    // Bridge side.
    modport slave (
        input  cpu_data_en, cpu_data_wen, cpu_data_addr, cpu_data_wdata,
        output cpu_data_rdata,
        output slv_en, slv_wen, slv_addr, slv_wdata,
        input  slv_rdata
    );

endinterface

// File: rtl/bridge_addr_dec.sv
// Priority address decoder: per-slave base/mask window match, lowest index wins.
// Latency: combinational.
// No backpressure.
module bridge_addr_dec
    import bridge_1xn_pkg::*;
#(
    parameter int                      N_SLV    = 2,
    parameter logic [N_SLV*XLEN-1:0]   SLV_BASE = {DSRAM_BASE, CONF_BASE},
    parameter logic [N_SLV*XLEN-1:0]   SLV_MASK = {DSRAM_MASK, CONF_MASK}
) (
    input  logic [XLEN-1:0]  addr,
    output logic [N_SLV-1:0] sel,
    output logic             miss_n
);

    logic [N_SLV-1:0] hit;

    always_comb begin
        hit = '0;
        for (int i = 0; i < N_SLV; i++) begin
            hit[i] = ((addr & SLV_MASK[i*XLEN +: XLEN]) ==
                      (SLV_BASE[i*XLEN +: XLEN] & SLV_MASK[i*XLEN +: XLEN]));
        end
    end

    // Scan from the top so the lowest matching index is the last one written.
    always_comb begin
        sel = '0;
        for (int i = N_SLV - 1; i >= 0; i--) begin
            if (hit[i]) begin
                sel    = '0;
                sel[i] = 1'b1;
            end
        end
    end

    assign miss_n = |hit;

endmodule

// File: rtl/bridge_1xn.sv
// 1-to-N data bridge: decodes, routes requests, returns rdata from last selected slave.
// Latency: request 0 cycles, rdata and dec_err 1 cycle.
// No backpressure: every cycle accepts a new access.
module bridge_1xn
    import bridge_1xn_pkg::*;
#(
    parameter int                      N_SLV     = 2,
    parameter logic [N_SLV*XLEN-1:0]   SLV_BASE  = {DSRAM_BASE, CONF_BASE},
    parameter logic [N_SLV*XLEN-1:0]   SLV_MASK  = {DSRAM_MASK, CONF_MASK},
    parameter logic [XLEN-1:0]         MISS_DATA = MISS_DATA_DEF
) (
    input  logic              clk,
    input  logic              reset,
    bridge_1xn_if.slave       bus,
    output logic              dec_err,
    output logic [XLEN-1:0]   err_addr,
    output logic [7:0]        err_cnt
);

    logic [N_SLV-1:0] sel;
    logic             miss_n;
    logic             miss;
    logic [N_SLV-1:0] sel_act;

    logic [N_SLV:0]   rsel_q, rsel_d;
    logic             dec_err_q, dec_err_d;
    logic [XLEN-1:0]  err_addr_q, err_addr_d;
    logic [7:0]       err_cnt_q, err_cnt_d;

    bridge_addr_dec #(
        .N_SLV    (N_SLV),
        .SLV_BASE (SLV_BASE),
        .SLV_MASK (SLV_MASK)
    ) u_dec (
        .addr   (bus.cpu_data_addr),
        .sel    (sel),
        .miss_n (miss_n)
    );

    assign miss    = bus.cpu_data_en & ~miss_n;
    assign sel_act = bus.cpu_data_en ? sel : '0;

    // Unselected ports see all-zero fields, so idle slaves never observe stray traffic.
    always_comb begin
        bus.slv_en    = '0;
        bus.slv_wen   = '0;
        bus.slv_addr  = '0;
        bus.slv_wdata = '0;
        for (int i = 0; i < N_SLV; i++) begin
            if (sel_act[i]) begin
                bus.slv_en[i]    = 1'b1;
                bus.slv_wen[i]   = bus.cpu_data_wen;
                bus.slv_addr[i]  = bus.cpu_data_addr;
                bus.slv_wdata[i] = bus.cpu_data_wdata;
            end
        end
    end

    always_comb begin
        rsel_d     = rsel_q;
        dec_err_d  = miss;
        err_addr_d = err_addr_q;
        err_cnt_d  = err_cnt_q;
        if (bus.cpu_data_en) begin
            rsel_d = {miss, sel};
        end
        if (miss) begin
            err_addr_d = bus.cpu_data_addr;
            if (err_cnt_q != 8'hFF) begin
                err_cnt_d = err_cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rsel_q     <= '0;
            dec_err_q  <= 1'b0;
            err_addr_q <= '0;
            err_cnt_q  <= '0;
        end else begin
            rsel_q     <= rsel_d;
            dec_err_q  <= dec_err_d;
            err_addr_q <= err_addr_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    // Held rsel_q keeps rdata following the last slave's (held) SRAM output while idle.
    always_comb begin
        bus.cpu_data_rdata = '0;
        for (int i = 0; i < N_SLV; i++) begin
            if (rsel_q[i]) begin
                bus.cpu_data_rdata = bus.slv_rdata[i];
            end
        end
        if (rsel_q[N_SLV]) begin
            bus.cpu_data_rdata = MISS_DATA;
        end
    end

    assign dec_err  = dec_err_q;
    assign err_addr = err_addr_q;
    assign err_cnt  = err_cnt_q;

endmodule
